// File: rtl/wb_pkg.sv
// Shared types and sizes for the register-file writeback scheduler.
package wb_pkg;

  localparam int XLEN_DEF = 64;
  localparam int REG_NUM  = 32;
  localparam int REG_AW   = 5;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-input round-robin arbiter (ALU vs LSU) that owns the last-grant flop.
module wb_rr_arb2 import wb_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic req_alu,
  input  logic req_lsu,
  output logic gnt_alu,
  output logic gnt_lsu
);

  wb_src_e last_grant_reg;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    gnt_alu = req_alu && (!req_lsu || (last_grant_reg == WB_LSU));
    gnt_lsu = req_lsu && !gnt_alu;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_reg <= WB_LSU;
    end else if (gnt_alu) begin
      last_grant_reg <= WB_ALU;
    end else if (gnt_lsu) begin
      last_grant_reg <= WB_LSU;
    end
  end

endmodule

// File: rtl/reg_wb_sched.sv
// Writeback scheduler + per-register pending-write scoreboard for the integer RF.
// Optional macro WB_BYPASS_EN adds rs1/rs2 forwarding from the RF write port.
module reg_wb_sched import wb_pkg::*; #(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  output logic              issue_ready,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              lsu_ready,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata
`ifdef WB_BYPASS_EN
  ,
  output logic              rs1_fwd,
  output logic              rs2_fwd,
  output logic [XLEN-1:0]   rs1_fwd_data,
  output logic [XLEN-1:0]   rs2_fwd_data
`endif
);

  logic [REG_NUM-1:0][CNT_W-1:0] cnt_vec;
  logic                          xfer;
  logic                          issue_take;
  logic [REG_AW-1:0]             win_rd;
  logic [XLEN-1:0]               win_data;
  logic [CNT_W-1:0]              rs1_cnt;
  logic [CNT_W-1:0]              rs2_cnt;

  wb_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_alu (alu_valid),
    .req_lsu (lsu_valid),
    .gnt_alu (alu_ready),
    .gnt_lsu (lsu_ready)
  );

  always_comb begin
    xfer     = alu_ready || lsu_ready;
    win_rd   = alu_ready ? alu_rd   : lsu_rd;
    win_data = alu_ready ? alu_data : lsu_data;
  end

  // Writes to x0 are accepted from the requester but never reach the RF.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= xfer && (win_rd != '0);
      if (xfer && (win_rd != '0)) begin
        rf_waddr <= win_rd;
        rf_wdata <= win_data;
      end
    end
  end

  // A retiring write to the same register frees its slot in the same cycle.
  assign issue_ready = (cnt_vec[issue_rd] != '1) || (rf_wen && (rf_waddr == issue_rd));
  assign issue_take  = issue_valid && issue_ready && (issue_rd != '0);

  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign cnt_vec[gi] = '0;
      end else begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        logic             inc;
        logic             dec;

        assign inc = issue_take && (issue_rd == REG_AW'(gi));
        // A stray write to an idle register is ignored rather than wrapping.
        assign dec = rf_wen && (rf_waddr == REG_AW'(gi)) && (cnt_reg != '0);

        always_ff @(posedge clk) begin
          if (!rst_n) begin
            cnt_reg <= '0;
          end else if (inc && !dec) begin
            cnt_reg <= cnt_reg + 1'b1;
          end else if (dec && !inc) begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        assign cnt_vec[gi] = cnt_reg;
      end
    end
  endgenerate

  assign rs1_cnt = cnt_vec[rs1_addr];
  assign rs2_cnt = cnt_vec[rs2_addr];

`ifdef WB_BYPASS_EN
  // The last outstanding write is on the port now: hand its data straight to decode.
  assign rs1_fwd      = rf_wen && (rf_waddr == rs1_addr) && (rs1_addr != '0) && (rs1_cnt == CNT_W'(1));
  assign rs2_fwd      = rf_wen && (rf_waddr == rs2_addr) && (rs2_addr != '0) && (rs2_cnt == CNT_W'(1));
  assign rs1_fwd_data = rf_wdata;
  assign rs2_fwd_data = rf_wdata;
  assign rs1_busy     = (rs1_cnt != '0) && !rs1_fwd;
  assign rs2_busy     = (rs2_cnt != '0) && !rs2_fwd;
`else
  assign rs1_busy = (rs1_cnt != '0);
  assign rs2_busy = (rs2_cnt != '0);
`endif

  always_ff @(posedge clk) begin
    if (rst_n && rf_wen) begin
      assert (cnt_vec[rf_waddr] != '0)
        else $error("reg_wb_sched: writeback to x%0d with no pending write", rf_waddr);
    end
  end

endmodule

// File: tb/tb_reg_wb_sched.sv
// Table-driven bench for reg_wb_sched with a queue scoreboard for RF writes.
module tb_reg_wb_sched;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        alu_valid, lsu_valid;
  logic [4:0]  alu_rd, lsu_rd;
  logic [63:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
`ifdef WB_BYPASS_EN
  logic        rs1_fwd, rs2_fwd;
  logic [63:0] rs1_fwd_data, rs2_fwd_data;
`endif

  always #5 clk = ~clk;

  reg_wb_sched #(.XLEN(64), .CNT_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .lsu_valid   (lsu_valid),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .lsu_ready   (lsu_ready),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
`ifdef WB_BYPASS_EN
    ,
    .rs1_fwd      (rs1_fwd),
    .rs2_fwd      (rs2_fwd),
    .rs1_fwd_data (rs1_fwd_data),
    .rs2_fwd_data (rs2_fwd_data)
`endif
  );

  typedef struct {
    logic        rstn;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        av;
    logic [4:0]  ard;
    logic [63:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [63:0] ld;
    logic        e_ir;
    logic        e_b1;
    logic        e_b2;
    logic        e_ar;
    logic        e_lr;
    logic        e_f1;
    logic        e_f2;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  vec_t vecs[$];
  wr_t  exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(int rstn, int iv, int ird, int r1, int r2,
                              int av, int ard, longint ad, int lv, int lrd, longint ld,
                              int ir, int b1, int b2, int ar, int lr, int f1, int f2);
    vec_t v;
    v.rstn = (rstn != 0); v.iv = (iv != 0); v.ird = 5'(ird);
    v.r1 = 5'(r1); v.r2 = 5'(r2);
    v.av = (av != 0); v.ard = 5'(ard); v.ad = 64'(ad);
    v.lv = (lv != 0); v.lrd = 5'(lrd); v.ld = 64'(ld);
    v.e_ir = (ir != 0); v.e_b1 = (b1 != 0); v.e_b2 = (b2 != 0);
    v.e_ar = (ar != 0); v.e_lr = (lr != 0); v.e_f1 = (f1 != 0); v.e_f2 = (f2 != 0);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rs1_addr = 5'd5;
    #1;
    chk("reset_rf_wen",   -1, 64'(rf_wen),   64'd0);
    chk("reset_rf_waddr", -1, 64'(rf_waddr), 64'd0);
    chk("reset_rf_wdata", -1, rf_wdata,      64'd0);
    chk("reset_rs1_busy", -1, 64'(rs1_busy), 64'd0);

    //   rstn iv ird r1 r2 av ard ad       lv lrd ld      ir b1 b2 ar lr f1 f2
    add(1, 1, 5, 5, 0, 0, 0, 0,       0, 0, 0,        1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 5, 0, 1, 5, 'h1234,  0, 0, 0,        1, 1, 0, 1, 0, 0, 0);
    add(1, 0, 0, 5, 0, 0, 0, 0,       0, 0, 0,        1, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 5, 0, 0, 0, 0,       0, 0, 0,        1, 0, 0, 0, 0, 0, 0);
    // arbitration: rd3 and rd4 pre-issued twice, both requesters contend
    add(1, 1, 3, 0, 0, 0, 0, 0,       0, 0, 0,        1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 3, 0, 0, 0, 0, 0,       0, 0, 0,        1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4, 0, 0, 0, 0, 0,       0, 0, 0,        1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4, 0, 0, 0, 0, 0,       0, 0, 0,        1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 3, 4, 1, 3, 'hA1,    1, 4, 'hB1,     1, 1, 1, 0, 1, 0, 0);
    add(1, 0, 0, 3, 4, 1, 3, 'hA1,    1, 4, 'hB2,     1, 1, 1, 1, 0, 0, 0);
    add(1, 0, 0, 3, 4, 1, 3, 'hA2,    1, 4, 'hB2,     1, 1, 1, 0, 1, 0, 0);
    add(1, 0, 0, 3, 4, 1, 3, 'hA2,    0, 0, 0,        1, 1, 1, 1, 0, 0, 1);
    add(1, 0, 0, 3, 4, 0, 0, 0,       0, 0, 0,        1, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 3, 4, 0, 0, 0,       0, 0, 0,        1, 0, 0, 0, 0, 0, 0);
    // saturation of rd7
    add(1, 1, 7, 7, 0, 0, 0, 0,       0, 0, 0,        1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 7, 7, 0, 0, 0, 0,       0, 0, 0,        1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 7, 7, 0, 0, 0, 0,       0, 0, 0,        1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 7, 7, 0, 1, 7, 'h77,    0, 0, 0,        0, 1, 0, 1, 0, 0, 0);
    add(1, 1, 7, 7, 0, 0, 0, 0,       0, 0, 0,        1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 7, 7, 0, 0, 0, 0,       0, 0, 0,        0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 7, 0, 1, 7, 'h71,    0, 0, 0,        1, 1, 0, 1, 0, 0, 0);
    add(1, 0, 0, 7, 0, 1, 7, 'h72,    0, 0, 0,        1, 1, 0, 1, 0, 0, 0);
    add(1, 0, 0, 7, 0, 1, 7, 'h73,    0, 0, 0,        1, 1, 0, 1, 0, 0, 0);
    add(1, 0, 0, 7, 0, 0, 0, 0,       0, 0, 0,        1, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 7, 0, 0, 0, 0,       0, 0, 0,        1, 0, 0, 0, 0, 0, 0);
    // same-cycle issue and retire of rd9 with one write pending
    add(1, 1, 9, 0, 9, 0, 0, 0,       0, 0, 0,        1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 9, 0, 0, 0,       1, 9, 'h99,     1, 0, 1, 0, 1, 0, 0);
    add(1, 1, 9, 0, 9, 0, 0, 0,       0, 0, 0,        1, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 9, 0, 0, 0,       1, 9, 'h9A,     1, 0, 1, 0, 1, 0, 0);
    add(1, 0, 0, 0, 9, 0, 0, 0,       0, 0, 0,        1, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 9, 0, 0, 0,       0, 0, 0,        1, 0, 0, 0, 0, 0, 0);
    // x0 writeback is accepted but never written; x0 never busy
    add(1, 1, 0, 0, 0, 1, 0, 'hFFFF,  0, 0, 0,        1, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,        1, 0, 0, 0, 0, 0, 0);
    // reset with cnt[5]=2, a visible write and a transfer in flight
    add(1, 1, 5, 5, 0, 0, 0, 0,       0, 0, 0,        1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 5, 5, 0, 0, 0, 0,       0, 0, 0,        1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 5, 0, 1, 5, 'h55,    0, 0, 0,        1, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 5, 0, 1, 5, 'h56,    0, 0, 0,        1, 1, 0, 1, 0, 0, 0);
    add(1, 0, 0, 5, 0, 1, 0, 'h1,     1, 0, 'h2,      1, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 5, 0, 0, 0, 0,       1, 0, 'h2,      1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 5, 0, 0, 0, 0,       0, 0, 0,        1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      wr_t  w;
      logic exp_wen;
      logic eb1, eb2;
      v = vecs[i];
      rst_n = v.rstn; issue_valid = v.iv; issue_rd = v.ird;
      rs1_addr = v.r1; rs2_addr = v.r2;
      alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
      lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
      #1;
`ifdef WB_BYPASS_EN
      eb1 = v.e_b1 && !v.e_f1;
      eb2 = v.e_b2 && !v.e_f2;
      chk("rs1_fwd", i, 64'(rs1_fwd), 64'(v.e_f1));
      chk("rs2_fwd", i, 64'(rs2_fwd), 64'(v.e_f2));
`else
      eb1 = v.e_b1;
      eb2 = v.e_b2;
`endif
      chk("issue_ready", i, 64'(issue_ready), 64'(v.e_ir));
      chk("rs1_busy",    i, 64'(rs1_busy),    64'(eb1));
      chk("rs2_busy",    i, 64'(rs2_busy),    64'(eb2));
      chk("alu_ready",   i, 64'(alu_ready),   64'(v.e_ar));
      chk("lsu_ready",   i, 64'(lsu_ready),   64'(v.e_lr));

      exp_wen = (exp_q.size() != 0);
      chk("rf_wen", i, 64'(rf_wen), 64'(exp_wen));
      if (exp_wen) begin
        w = exp_q.pop_front();
        chk("rf_waddr", i, 64'(rf_waddr), 64'(w.addr));
        chk("rf_wdata", i, rf_wdata, w.data);
        $display("vec %0d rf write addr=%0d data=%0h", i, rf_waddr, rf_wdata);
`ifdef WB_BYPASS_EN
        if (v.e_f1) chk("rs1_fwd_data", i, rs1_fwd_data, w.data);
        if (v.e_f2) chk("rs2_fwd_data", i, rs2_fwd_data, w.data);
`endif
      end else begin
        $display("vec %0d no rf write, alu_ready=%0b lsu_ready=%0b", i, alu_ready, lsu_ready);
      end

      if (v.rstn) begin
        if (v.av && v.e_ar && (v.ard != 5'd0)) exp_q.push_back('{addr: v.ard, data: v.ad});
        if (v.lv && v.e_lr && (v.lrd != 5'd0)) exp_q.push_back('{addr: v.lrd, data: v.ld});
      end
      @(posedge clk);
      @(negedge clk);
    end

    // after the mid-run reset only x0 writebacks occurred, so the port keeps its reset values
    rst_n = 1'b1; issue_valid = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
    #1;
    chk("post_reset_rf_waddr", -2, 64'(rf_waddr), 64'd0);
    chk("post_reset_rf_wdata", -2, rf_wdata,      64'd0);
    chk("post_reset_rf_wen",   -2, 64'(rf_wen),   64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_wb_sched.md
Name: reg_wb_sched

Overview:
Writeback scheduler and scoreboard in front of the 32x64 integer register file (single write port, x0 reads zero).
- Shares the single write port between two writeback requesters, ALU and LSU, using round-robin arbitration.
- Tracks outstanding writes per architectural register so decode can stall on RAW hazards.
- Drives the register file write port (write_en / rd_addr / rd) from a registered output stage.

Parameters:
XLEN, 64, data width of writeback and register file.
CNT_W, 2, width of per-register pending-write counter (max outstanding = 2^CNT_W-1).

Ports:
clk  in  1  clock.
rst_n  in  1  reset, synchronous, active-low.
issue_valid  in  1  decode issues an instruction that will write issue_rd.
issue_rd  in  5  destination register of issuing instruction.
issue_ready  out  1  low when issue_rd counter saturated; decode must hold.
rs1_addr  in  5  decode source 1 query.
rs2_addr  in  5  decode source 2 query.
rs1_busy  out  1  rs1_addr has pending write (combinational).
rs2_busy  out  1  rs2_addr has pending write (combinational).
alu_valid  in  1  ALU writeback request.
alu_rd  in  5  ALU destination.
alu_data  in  XLEN  ALU result.
alu_ready  out  1  ALU request granted this cycle.
lsu_valid  in  1  LSU writeback request.
lsu_rd  in  5  LSU destination.
lsu_data  in  XLEN  load result.
lsu_ready  out  1  LSU request granted this cycle.
rf_wen  out  1  register file write_en.
rf_waddr  out  5  register file rd_addr.
rf_wdata  out  XLEN  register file rd.

Behaviour:
- Reset (rst_n low at posedge):
  - All 32 counters = 0.
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - last_grant = LSU, so the ALU wins the first tie.
- Handshake: valid/ready. A requester holds valid, rd and data stable until it sees ready. A transfer occurs when valid && ready.
- Arbitration (combinational grant):
  - Single requester: that requester is granted.
  - Both requesting: grant the one not equal to last_grant.
  - last_grant updates on every transfer.
  - At most one ready high per cycle.
  - Output stage is always able to accept (no backpressure from the register file), so a lone requester gets ready in the same cycle.
- Output stage (1-cycle latency):
  - On a transfer, the next posedge loads rf_waddr/rf_wdata from the winner and sets rf_wen=1.
  - Otherwise rf_wen=0; rf_waddr/rf_wdata hold.
  - Transfer with rd==0: rf_wen stays 0 and the data is discarded.
- Scoreboard:
  - cnt[r] increments on issue_valid && issue_ready && issue_rd==r, r!=0.
  - cnt[r] decrements when rf_wen && rf_waddr==r (the write is visible in the register file that cycle, so reads are correct the following cycle).
  - Increment and decrement of the same r in one cycle: unchanged.
  - cnt[0] is constant 0; issue to x0 is always ready and never counted.
- rs*_busy = (cnt[addr]!=0). Address 0 is never busy.
- issue_ready = !(cnt[issue_rd] == all-ones) || (rf_wen && rf_waddr==issue_rd). Pending decrement frees a slot the same cycle.
- Writeback to a register whose cnt==0 is a protocol error:
  - Counter is not decremented (no underflow).
  - In simulation, $error is raised.
- Reset mid-operation:
  - In-flight output write is dropped: rf_wen=0 next cycle.
  - All counters cleared.
  - Requesters are reset by the same rst_n.

Optional Feature:
WB_BYPASS_EN
- Defined:
  - Adds outputs rs1_fwd, rs2_fwd (1 bit each) and rs1_fwd_data, rs2_fwd_data (XLEN each).
  - When rf_wen && rf_waddr==rsN_addr && rsN_addr!=0 && cnt==1: rsN_fwd=1, rsN_fwd_data=rf_wdata, and rsN_busy is forced 0 that cycle.
  - Saves one stall cycle.
- Undefined:
  - Those ports are absent.
  - Busy stays asserted through the rf_wen cycle.

Decomposition:
- Shared package wb_pkg:
  - XLEN_DEF=64, REG_NUM=32, REG_AW=5.
  - Enum wb_src_e {WB_ALU=0, WB_LSU=1}, used for last_grant.
- One sub-module: wb_rr_arb2, a 2-input round-robin arbiter with the last_grant flop.
- Scoreboard counters and output stage stay in the top module.

Test Plan:
- Reset, then issue rd=5: rs1_addr=5 gives rs1_busy=1. ALU wb rd=5 data=0x1234 gives alu_ready=1; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234. Cycle after: rs1_busy=0.
- Both requesting every cycle (ALU rd=3, LSU rd=4, pre-issued twice each): grants alternate ALU, LSU, ALU, LSU; exactly one ready per cycle.
- Issue rd=7 three times (cnt=3): fourth issue sees issue_ready=0. Retire one: issue_ready=1 in the rf_wen cycle; cnt stays 3 if the issue is taken.
- Issue and retire rd=9 in the same cycle with cnt=1: cnt stays 1 and rs2_busy stays 1.
- Writeback rd=0 data=0xFFFF: ready=1 and rf_wen stays 0. rs1_addr=0 is never busy; issue rd=0 always ready.
- Assert rst_n=0 with cnt[5]=2 and a pending output write: next cycle rf_wen=0 and rs1_busy(5)=0. With WB_BYPASS_EN and cnt=1 on the rf_wen cycle: rs1_fwd=1 and rs1_fwd_data equals rf_wdata.
